// File: rtl/fft_bf_sched.sv
// Address and strobe sequencer for an in-place radix-2 DIT FFT: walks every stage and
// butterfly, issuing read pairs, twiddle addresses and the delayed write-back pairs.
module fft_bf_sched #(
  parameter int LOG2N    = 3,
  parameter int PIPE_LAT = 2,
  parameter int LOG2N_W  = $clog2(LOG2N + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic [LOG2N_W-1:0] stage,
  output logic               rd_en,
  output logic [LOG2N-1:0]   rd_addr_a,
  output logic [LOG2N-1:0]   rd_addr_b,
  output logic [LOG2N-2:0]   tw_addr,
  output logic               wr_en,
  output logic [LOG2N-1:0]   wr_addr_a,
  output logic [LOG2N-1:0]   wr_addr_b
);

  // Handshake: start is a request that is only taken in IDLE on a cycle with stall=0;
  // stall=1 freezes every register and gates the visible rd_en/wr_en strobes, so a
  // strobe counts exactly once, on the first unstalled cycle it is presented.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [LOG2N-2:0]   B_LAST     = {(LOG2N-1){1'b1}};
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PIPE_LAT - 1);
  localparam logic [LOG2N_W-1:0] LAST_STAGE = LOG2N_W'(LOG2N - 1);

  logic [1:0]         state_q, state_n;
  logic [LOG2N_W-1:0] stage_q, stage_n;
  logic [LOG2N-2:0]   b_q, b_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               rd_q, rd_n;
  logic [LOG2N-1:0]   ra_q, rb_q;
  logic [LOG2N-2:0]   tw_q;

  logic               wr_d [PIPE_LAT];
  logic [LOG2N-1:0]   wa_d [PIPE_LAT];
  logic [LOG2N-1:0]   wb_d [PIPE_LAT];

  logic [LOG2N-1:0]   ra_n, rb_n;
  logic [LOG2N-2:0]   tw_n;

  always_comb begin
    state_n = state_q;
    stage_n = stage_q;
    b_n     = b_q;
    cnt_n   = cnt_q;
    rd_n    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          stage_n = '0;
          b_n     = '0;
          rd_n    = 1'b1;
        end
      end
      ISSUE: begin
        if (b_q == B_LAST) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else begin
          b_n  = b_q + 1'b1;
          rd_n = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          if (stage_q != LAST_STAGE) begin
            state_n = ISSUE;
            stage_n = stage_q + 1'b1;
            b_n     = '0;
            rd_n    = 1'b1;
          end else begin
            state_n = DONE;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Addresses are computed for the butterfly about to be presented, so they are
  // registered alongside rd_en rather than one cycle behind it.
  logic [LOG2N-1:0] b_ext, span, mask;
  always_comb begin
    b_ext = {1'b0, b_n};
    span  = LOG2N'(1) << stage_n;
    mask  = span - LOG2N'(1);
    ra_n  = (((b_ext >> stage_n) << stage_n) << 1) | (b_ext & mask);
    rb_n  = ra_n + span;
    tw_n  = (b_n & mask[LOG2N-2:0]) << (LOG2N_W'(LOG2N - 1) - stage_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      tw_q    <= '0;
    end else if (!stall) begin
      state_q <= state_n;
      stage_q <= stage_n;
      b_q     <= b_n;
      cnt_q   <= cnt_n;
      rd_q    <= rd_n;
      if (rd_n) begin
        ra_q <= ra_n;
        rb_q <= rb_n;
        tw_q <= tw_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        wr_d[i] <= 1'b0;
        wa_d[i] <= '0;
        wb_d[i] <= '0;
      end
    end else if (!stall) begin
      wr_d[0] <= rd_q;
      wa_d[0] <= ra_q;
      wb_d[0] <= rb_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wr_d[i] <= wr_d[i-1];
        wa_d[i] <= wa_d[i-1];
        wb_d[i] <= wb_d[i-1];
      end
    end
  end

  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign stage     = stage_q;
  assign rd_en     = rd_q & ~stall;
  assign rd_addr_a = ra_q;
  assign rd_addr_b = rb_q;
  assign tw_addr   = tw_q;
  assign wr_en     = wr_d[PIPE_LAT-1] & ~stall;
  assign wr_addr_a = wa_d[PIPE_LAT-1];
  assign wr_addr_b = wb_d[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_bf_sched.sv
// Directed bench for fft_bf_sched: cycle table for an N=8 run, stall/start/reset
// corner sequences, and a randomly stalled N=16 run checked against a scoreboard.
module tb_fft_bf_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=8, PIPE_LAT=2 instance
  logic       rst_n, start, stall;
  logic       busy, done, rd_en, wr_en;
  logic [1:0] stage, tw_addr;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;

  fft_bf_sched #(.LOG2N(3), .PIPE_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  // N=16, PIPE_LAT=1 instance
  logic       rst4_n, start4, stall4;
  logic       busy4, done4, rd_en4, wr_en4;
  logic [2:0] stage4, tw4;
  logic [3:0] ra4, rb4, wa4, wb4;

  fft_bf_sched #(.LOG2N(4), .PIPE_LAT(1)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .stall(stall4),
    .busy(busy4), .done(done4), .stage(stage4),
    .rd_en(rd_en4), .rd_addr_a(ra4), .rd_addr_b(rb4), .tw_addr(tw4),
    .wr_en(wr_en4), .wr_addr_a(wa4), .wr_addr_b(wb4)
  );

  typedef struct {
    logic       rd;
    logic [2:0] ra, rb;
    logic [1:0] tw;
    logic       wr;
    logic [2:0] wa, wb;
    logic       bsy, dn;
    logic [1:0] stg;
  } vec_t;

  vec_t tbl[20];
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] exp_q[$];

  function automatic vec_t mk(input logic rd, input int ra, input int rb, input int tw,
                              input logic wr, input int wa, input int wb,
                              input logic bsy, input logic dn, input int stg);
    vec_t v;
    v.rd = rd; v.ra = 3'(ra); v.rb = 3'(rb); v.tw = 2'(tw);
    v.wr = wr; v.wa = 3'(wa); v.wb = 3'(wb);
    v.bsy = bsy; v.dn = dn; v.stg = 2'(stg);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int done_cnt, done_cyc, bad, active;
    logic [7:0] got_rd[$], got_wr[$];
    int rd_cnt[4][16];
    bit seen;

    tbl[0]  = mk(0,0,0,0, 0,0,0, 0,0,0);
    tbl[1]  = mk(1,0,1,0, 0,0,0, 1,0,0);
    tbl[2]  = mk(1,2,3,0, 0,0,0, 1,0,0);
    tbl[3]  = mk(1,4,5,0, 1,0,1, 1,0,0);
    tbl[4]  = mk(1,6,7,0, 1,2,3, 1,0,0);
    tbl[5]  = mk(0,6,7,0, 1,4,5, 1,0,0);
    tbl[6]  = mk(0,6,7,0, 1,6,7, 1,0,0);
    tbl[7]  = mk(1,0,2,0, 0,6,7, 1,0,1);
    tbl[8]  = mk(1,1,3,2, 0,6,7, 1,0,1);
    tbl[9]  = mk(1,4,6,0, 1,0,2, 1,0,1);
    tbl[10] = mk(1,5,7,2, 1,1,3, 1,0,1);
    tbl[11] = mk(0,5,7,2, 1,4,6, 1,0,1);
    tbl[12] = mk(0,5,7,2, 1,5,7, 1,0,1);
    tbl[13] = mk(1,0,4,0, 0,5,7, 1,0,2);
    tbl[14] = mk(1,1,5,1, 0,5,7, 1,0,2);
    tbl[15] = mk(1,2,6,2, 1,0,4, 1,0,2);
    tbl[16] = mk(1,3,7,3, 1,1,5, 1,0,2);
    tbl[17] = mk(0,3,7,3, 1,2,6, 1,0,2);
    tbl[18] = mk(0,3,7,3, 1,3,7, 1,0,2);
    tbl[19] = mk(0,3,7,3, 0,3,7, 0,1,2);

    rst4_n = 1'b0; start4 = 1'b0; stall4 = 1'b0;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    tick();
    #1;
    chk("reset rd_en", rd_en, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset addr", {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b, stage}, 0);

    // Tests 1/2: full unstalled run against the cycle table
    do_reset();
    for (int c = 0; c < 20; c++) begin
      start = (c == 0);
      @(negedge clk);
      chk($sformatf("t1 rd_en c%0d", c), rd_en, tbl[c].rd);
      chk($sformatf("t1 rd_addr_a c%0d", c), rd_addr_a, tbl[c].ra);
      chk($sformatf("t1 rd_addr_b c%0d", c), rd_addr_b, tbl[c].rb);
      chk($sformatf("t1 tw_addr c%0d", c), tw_addr, tbl[c].tw);
      chk($sformatf("t2 wr_en c%0d", c), wr_en, tbl[c].wr);
      chk($sformatf("t2 wr_addr_a c%0d", c), wr_addr_a, tbl[c].wa);
      chk($sformatf("t2 wr_addr_b c%0d", c), wr_addr_b, tbl[c].wb);
      chk($sformatf("t2 busy c%0d", c), busy, tbl[c].bsy);
      chk($sformatf("t1 done c%0d", c), done, tbl[c].dn);
      chk($sformatf("t1 stage c%0d", c), stage, tbl[c].stg);
      tick();
    end
    start = 1'b0;

    // Test 3: stall @8-10 in stage 1
    do_reset();
    exp_q.delete();
    for (int c = 0; c < 20; c++)
      if (tbl[c].rd) exp_q.push_back({2'b00, tbl[c].ra, tbl[c].rb});
    done_cnt = 0; done_cyc = -1;
    for (int c = 0; c < 30; c++) begin
      start = (c == 0);
      stall = (c >= 8 && c <= 10);
      @(negedge clk);
      if (stall) chk($sformatf("t3 gated c%0d", c), {rd_en, wr_en}, 0);
      if (rd_en) got_rd.push_back({2'b00, rd_addr_a, rd_addr_b});
      if (wr_en) got_wr.push_back({2'b00, wr_addr_a, wr_addr_b});
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      tick();
    end
    start = 1'b0; stall = 1'b0;
    chk("t3 done cycle", done_cyc, 22);
    chk("t3 done count", done_cnt, 1);
    chk("t3 rd count", got_rd.size(), 12);
    chk("t3 wr count", got_wr.size(), 12);
    for (int i = 0; i < 12 && i < got_rd.size(); i++)
      chk($sformatf("t3 rd seq %0d", i), got_rd[i], exp_q[i]);
    for (int i = 0; i < 12 && i < got_wr.size(); i++)
      chk($sformatf("t3 wr seq %0d", i), got_wr[i], exp_q[i]);

    // Test 4: start while busy and in DONE ignored, start in IDLE accepted
    do_reset();
    done_cnt = 0;
    for (int c = 0; c < 23; c++) begin
      start = (c == 0 || c == 5 || c == 19 || c == 20);
      @(negedge clk);
      if (done && c <= 20) done_cnt++;
      if (c == 7)  chk("t4 stage after ignored start", {stage, rd_addr_a, rd_addr_b}, {2'd1, 3'd0, 3'd2});
      if (c == 19) chk("t4 done @19", done, 1);
      if (c == 20) chk("t4 idle @20", {busy, done, rd_en}, 0);
      if (c == 21) chk("t4 new run rd @21", {rd_en, stage, rd_addr_a, rd_addr_b}, {1'b1, 2'd0, 3'd0, 3'd1});
      tick();
    end
    start = 1'b0;
    chk("t4 single done", done_cnt, 1);

    // Test 5: reset mid-run
    do_reset();
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      start = (c == 0);
      if (c == 9) rst_n = 1'b0;
      if (c == 10) rst_n = 1'b1;
      @(negedge clk);
      if (c == 8) chk("t5 running @8", {busy, rd_en}, 2'b11);
      if (c == 9) begin
        chk("t5 strobes @9", {rd_en, wr_en, busy, done}, 0);
        chk("t5 addrs @9", {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b, stage}, 0);
      end
      if (c > 9 && (rd_en || wr_en || busy || done)) bad++;
      tick();
    end
    start = 1'b0;
    chk("t5 idle after reset", bad, 0);

    // Test 6: N=16, PIPE_LAT=1, random stall, scoreboard
    rst4_n = 1'b0;
    tick();
    rst4_n = 1'b1;
    tick();
    exp_q.delete();
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++) rd_cnt[s][a] = 0;
    active = 0; seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      start4 = (c == 0);
      stall4 = (c == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (rd_en4) begin
        rd_cnt[stage4[1:0]][ra4]++;
        rd_cnt[stage4[1:0]][rb4]++;
        exp_q.push_back({ra4, rb4});
      end
      if (wr_en4) begin
        if (exp_q.size() == 0) chk("t6 wr without rd", 1, 0);
        else chk("t6 wr pair", {wa4, wb4}, exp_q.pop_front());
      end
      if (done4) seen = 1'b1;
      else if (c >= 1 && !stall4) active++;
      tick();
    end
    start4 = 1'b0; stall4 = 1'b0;
    chk("t6 done seen", seen, 1);
    chk("t6 unstalled cycles", active, 36);
    chk("t6 pending writes", exp_q.size(), 0);
    for (int s = 0; s < 4; s++) begin
      bad = 0;
      for (int a = 0; a < 16; a++) if (rd_cnt[s][a] != 1) bad++;
      chk($sformatf("t6 stage %0d reads once", s), bad, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
